// File: rtl/bcd_7448_scan_ctrl.sv
// Multiplexed MSD-first scan driver for one shared bcd_7448 with ripple-blank leading-zero suppression.
// All outputs are registered from next-state values, so a control sampled in one cycle shows in the next.
module bcd_7448_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      load,
  input  logic                      lz_en,
  input  logic                      lamp_test,
  input  logic                      blank,
  output logic [3:0]                bcd_out,
  output logic                      LT_out,
  output logic                      BI_out,
  output logic                      RBI_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done
);

  localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] MSD        = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic {GAP, DRIVE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      zero_run_q, zero_run_d;
  logic [4*NUM_DIGITS-1:0]   display_q, display_d;
  logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
  logic                      pend_vld_q, pend_vld_d;

  logic [3:0]                cur_nib, nib_d;
  logic                      supp_d;
  logic [NUM_DIGITS-1:0]     onehot_d;
  logic [NUM_DIGITS-1:0]     digit_en_d;
  logic [3:0]                bcd_d;
  logic                      lt_d, bi_d, rbi_d, frame_done_d;

  assign cur_nib = display_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    zero_run_d = zero_run_q;
    display_d  = display_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pending_d  = value_in;
      pend_vld_d = 1'b1;
    end
    if (state_q == GAP) begin
      if (cnt_q == GAP_LAST) begin
        state_d = DRIVE;
        cnt_d   = '0;
      end
    end else if (cnt_q == DWELL_LAST) begin
      state_d    = GAP;
      cnt_d      = '0;
      zero_run_d = zero_run_q & (cur_nib == 4'd0);
      if (idx_q == '0) begin
        // Frame boundary: the only point the display may change, so frames never tear.
        idx_d      = MSD;
        zero_run_d = 1'b1;
        if (load) begin
          display_d = value_in;
        end else if (pend_vld_q) begin
          display_d = pending_q;
        end
        pend_vld_d = 1'b0;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  assign nib_d    = display_d[{idx_d, 2'b00} +: 4];
  assign supp_d   = lz_en && zero_run_d && (nib_d == 4'd0) && (idx_d != '0);
  assign onehot_d = NUM_DIGITS'(1) << idx_d;

  always_comb begin
    digit_en_d   = '0;
    bcd_d        = 4'd0;
    lt_d         = 1'b1;
    bi_d         = 1'b0;
    rbi_d        = 1'b1;
    frame_done_d = (state_d == DRIVE) && (idx_d == '0) && (cnt_d == DWELL_LAST);
    if (state_d == DRIVE) begin
      if (lamp_test) begin
        digit_en_d = onehot_d;
        bcd_d      = nib_d;
        lt_d       = 1'b0;
        bi_d       = 1'b1;
      end else if (!blank) begin
        digit_en_d = onehot_d;
        bi_d       = 1'b1;
        bcd_d      = supp_d ? 4'd0 : nib_d;
        rbi_d      = !supp_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GAP;
      cnt_q      <= '0;
      idx_q      <= MSD;
      zero_run_q <= 1'b1;
      display_q  <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      digit_en   <= '0;
      bcd_out    <= 4'd0;
      LT_out     <= 1'b1;
      BI_out     <= 1'b0;
      RBI_out    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      zero_run_q <= zero_run_d;
      display_q  <= display_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      digit_en   <= digit_en_d;
      bcd_out    <= bcd_d;
      LT_out     <= lt_d;
      BI_out     <= bi_d;
      RBI_out    <= rbi_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bcd_7448_scan_ctrl.sv
// Directed bench for bcd_7448_scan_ctrl with NUM_DIGITS=4, DWELL=4, GAP=1 (20-cycle frames).
module tb_bcd_7448_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load, lz_en, lamp_test, blank;
  logic [3:0]  bcd_out;
  logic        LT_out, BI_out, RBI_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  int vec = 0;
  int err = 0;

  bcd_7448_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_en(lz_en),
    .lamp_test(lamp_test), .blank(blank), .bcd_out(bcd_out), .LT_out(LT_out),
    .BI_out(BI_out), .RBI_out(RBI_out), .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    chk("fd_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  // Starts at the negedge of a frame_done cycle and checks the next whole frame.
  // mode: 0 normal, 1 lamp test, 2 blanked. ld_d >= 0 loads ld_v during that digit's first DRIVE cycle.
  task automatic check_frame(input string tag, input logic [15:0] ebcd, input logic [3:0] erbi,
                             input int mode, input int ld_d, input logic [15:0] ld_v);
    logic [3:0] exp_bcd;
    for (int d = 3; d >= 0; d--) begin
      @(negedge clk);
      load = 1'b0;
      chk({tag, "_gap_en"}, {28'd0, digit_en}, 32'd0);
      chk({tag, "_gap_bi"}, {31'd0, BI_out}, 32'd0);
      chk({tag, "_gap_fd"}, {31'd0, frame_done}, 32'd0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (d == ld_d && c == 0) begin
          value_in = ld_v;
          load     = 1'b1;
        end else begin
          load = 1'b0;
        end
        exp_bcd = ebcd[4*d +: 4];
        chk({tag, "_en"}, {28'd0, digit_en}, (mode == 2) ? 32'd0 : (32'd1 << d));
        chk({tag, "_bi"}, {31'd0, BI_out}, (mode == 2) ? 32'd0 : 32'd1);
        chk({tag, "_lt"}, {31'd0, LT_out}, (mode == 1) ? 32'd0 : 32'd1);
        if (mode != 2) begin
          chk({tag, "_bcd"}, {28'd0, bcd_out}, {28'd0, exp_bcd});
          chk({tag, "_rbi"}, {31'd0, RBI_out}, {31'd0, erbi[d]});
        end
        chk({tag, "_fd"}, {31'd0, frame_done}, (d == 0 && c == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; value_in = 16'h0; load = 1'b0; lz_en = 1'b0; lamp_test = 1'b0; blank = 1'b0;
    @(negedge clk);
    chk("rst_en",  {28'd0, digit_en}, 32'd0);
    chk("rst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("rst_lt",  {31'd0, LT_out}, 32'd1);
    chk("rst_bi",  {31'd0, BI_out}, 32'd0);
    chk("rst_rbi", {31'd0, RBI_out}, 32'd1);
    chk("rst_fd",  {31'd0, frame_done}, 32'd0);

    rst = 1'b0; value_in = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    check_frame("plain", 16'h1234, 4'b1111, 0, -1, 16'h0);

    lz_en = 1'b1; value_in = 16'h0050; load = 1'b1;
    check_frame("lz0050", 16'h0050, 4'b0011, 0, -1, 16'h0);
    value_in = 16'h0000; load = 1'b1;
    check_frame("lz0000", 16'h0000, 4'b0001, 0, -1, 16'h0);
    value_in = 16'h0102; load = 1'b1;
    check_frame("lz0102", 16'h0102, 4'b0111, 0, -1, 16'h0);

    value_in = 16'h0000; load = 1'b1; lamp_test = 1'b1;
    check_frame("lamp", 16'h0000, 4'b1111, 1, -1, 16'h0);
    lamp_test = 1'b0; blank = 1'b1;
    check_frame("blank", 16'h0000, 4'b0001, 2, -1, 16'h0);
    lamp_test = 1'b1;
    check_frame("lampblank", 16'h0000, 4'b1111, 1, -1, 16'h0);

    lamp_test = 1'b0; blank = 1'b0; lz_en = 1'b0; value_in = 16'h1234; load = 1'b1;
    check_frame("midload", 16'h1234, 4'b1111, 0, 2, 16'h5678);
    check_frame("newval", 16'h5678, 4'b1111, 0, -1, 16'h0);

    repeat (13) @(negedge clk);
    chk("pre_rst_en",  {28'd0, digit_en}, 32'd2);
    chk("pre_rst_bcd", {28'd0, bcd_out}, 32'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_en",  {28'd0, digit_en}, 32'd0);
    chk("mid_rst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("mid_rst_lt",  {31'd0, LT_out}, 32'd1);
    chk("mid_rst_bi",  {31'd0, BI_out}, 32'd0);
    chk("mid_rst_rbi", {31'd0, RBI_out}, 32'd1);
    chk("mid_rst_fd",  {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_en",  {28'd0, digit_en}, 32'd8);
    chk("post_rst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("post_rst_bi",  {31'd0, BI_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
